taint_sum_scanner: RTL and testbench
====================================

Name: taint_sum_scanner

Overview:
Periodic sweep controller for the taint_sum outputs of the taint dff/mem cells in an instrumented design. It samples one source per cycle in round-robin order, accumulates a saturating total and tracks the hottest source. It publishes one report per sweep over a valid/ready handshake to the simulation logger, and raises a sticky alarm when the total exceeds a programmable threshold. It sits beside the instrumented SoC top and is clocked by the SoC clock.

Parameters:
N_SRC, 8, number of taint_sum sources (>=2)
SUM_W, 16, width of each taint_sum input (unsigned)
ACC_W, 24, width of total accumulator (>= SUM_W)
PERIOD, 1024, cycles from report acceptance to next sweep start (>=1)
RND_W, 16, round counter width

Ports:
CLK  in  1  clock, rising edge
ARST_N  in  1  asynchronous active-low reset
enable  in  1  level; run periodic sweeps while high
src_sum  in  N_SRC*SUM_W  flat taint_sum inputs; source i at [i*SUM_W +: SUM_W]
threshold  in  ACC_W  alarm threshold; sampled at sweep start
clr_alarm  in  1  one-cycle pulse; clears alarm
rpt_valid  out  1  report available
rpt_ready  in  1  logger accepts report
rpt_total  out  ACC_W  saturated sum of sweep
rpt_sat  out  1  total saturated during sweep
rpt_max_idx  out  $clog2(N_SRC)  index of largest sample
rpt_max_val  out  SUM_W  largest sample value
rpt_round  out  RND_W  sweep number, first sweep = 0
alarm  out  1  sticky, total > threshold seen
busy  out  1  state != IDLE

Behaviour:
- Reset (async, ARST_N=0): state IDLE; all outputs 0; accumulator, max, index, round, period counter 0.
- States: IDLE, SCAN, REPORT, WAIT.
- IDLE: enable=1 -> SCAN next cycle (first sweep immediate, no PERIOD wait); latch threshold; clear acc/max/sat; idx=0.
- SCAN: one source per cycle, idx 0..N_SRC-1; sample src_sum[idx] on that edge. Acc += sample, saturating at 2^ACC_W-1 and setting sat. Max updates only on strictly greater, so ties keep the lowest index; if all samples are 0 then max_idx=0, max_val=0. After idx N_SRC-1, go to REPORT. SCAN lasts exactly N_SRC cycles; idx wraps to 0.
- REPORT: rpt_valid=1 on the first cycle after the last sample. rpt_* are registered and stable while valid && !ready. Transfer happens on a cycle with valid && ready. On that edge: valid drops, round increments (wraps mod 2^RND_W); go to WAIT if enable=1, else IDLE.
- WAIT: counter loads PERIOD-1 at acceptance and decrements. At 0 with enable=1, go to SCAN (latch threshold, clear acc). enable=0 in WAIT -> IDLE immediately.
- enable drop during SCAN/REPORT: the sweep completes and reports; then IDLE.
- Alarm: set at the REPORT-entry edge if total > latched threshold (strict). clr_alarm clears it. Set and clear on the same edge: set wins. The alarm is independent of the handshake.
- src_sum X/unknown bits are treated as 0: sample = $isunknown ? 0 : value.
- Reset mid-SCAN or mid-REPORT: abort, no report, round returns to 0.
- No combinational path from rpt_ready to rpt_valid.

Test Plan:
- N_SRC=4, src={3,9,9,1}, threshold=20, ready=1, enable pulse-held -> rpt_valid 5 cycles after enable high; total=22, max_idx=1, max_val=9, round=0, alarm=1.
- ACC_W=16, SUM_W=16, all src=16'hFFFF -> rpt_total=16'hFFFF, rpt_sat=1; next sweep with src=0 -> total=0, sat=0.
- Hold rpt_ready=0 for 10 cycles while src changes -> rpt_* unchanged, valid stays 1; ready=1 -> accepted, round becomes 1; next rpt_valid exactly PERIOD+N_SRC+1 cycles later.
- Drop enable on SCAN cycle 2 -> report still issued, then busy=0 and no further sweeps.
- Alarm set: clr_alarm asserted on the same edge the alarm sets -> alarm=1; clr next cycle -> 0.
- ARST_N low during SCAN -> all outputs 0 immediately; re-enable -> first report has round=0.

Source files
------------

// File: rtl/taint_sum_scanner.sv
// Round-robin sweep of taint_sum sources: saturating total, hottest source, sticky over-threshold alarm.
// Latency: report valid N_SRC+1 edges after sweep start; rpt_* held stable while rpt_ready is low.
module taint_sum_scanner #(
    parameter int N_SRC  = 8,
    parameter int SUM_W  = 16,
    parameter int ACC_W  = 24,
    parameter int PERIOD = 1024,
    parameter int RND_W  = 16
) (
    input  logic                       CLK,
    input  logic                       ARST_N,
    input  logic                       enable,
    input  logic [N_SRC*SUM_W-1:0]     src_sum,
    input  logic [ACC_W-1:0]           threshold,
    input  logic                       clr_alarm,
    output logic                       rpt_valid,
    input  logic                       rpt_ready,
    output logic [ACC_W-1:0]           rpt_total,
    output logic                       rpt_sat,
    output logic [$clog2(N_SRC)-1:0]   rpt_max_idx,
    output logic [SUM_W-1:0]           rpt_max_val,
    output logic [RND_W-1:0]           rpt_round,
    output logic                       alarm,
    output logic                       busy
);
    localparam int IDX_W = $clog2(N_SRC);
    localparam int CNT_W = $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0] PER_M1   = CNT_W'(PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SRC - 1);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT, WAIT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q, acc_next;
    logic [ACC_W-1:0]   thr_q;
    logic               sat_q, sat_next;
    logic [SUM_W-1:0]   max_val_q, max_idx_dummy_unused_n;
    logic [IDX_W-1:0]   max_idx_q;
    logic [RND_W-1:0]   round_q;
    logic               alarm_q;
    logic               start, last, accept, set_alarm;
    logic [SUM_W-1:0]   raw, sample;
    logic [ACC_W:0]     ext, sum;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        last    = (state_q == SCAN) && (idx_q == IDX_LAST);
        accept  = (state_q == REPORT) && rpt_ready;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SCAN;
                    start   = 1'b1;
                end
            end
            SCAN: begin
                if (last) state_d = REPORT;
            end
            REPORT: begin
                if (rpt_ready) state_d = enable ? WAIT : IDLE;
            end
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = SCAN;
                    start   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Unknown source bits count as zero so an uninitialised cell cannot poison the total.
    always_comb begin
        raw    = src_sum[int'(idx_q)*SUM_W +: SUM_W];
        sample = $isunknown(raw) ? '0 : raw;
        ext    = '0;
        ext[SUM_W-1:0] = sample;
        sum    = {1'b0, acc_q} + ext;
        acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        sat_next = sat_q | sum[ACC_W];
        set_alarm = last && (acc_next > thr_q);
        max_idx_dummy_unused_n = '0;
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            thr_q     <= '0;
            sat_q     <= 1'b0;
            max_val_q <= '0;
            max_idx_q <= '0;
            round_q   <= '0;
            alarm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                acc_q     <= '0;
                sat_q     <= 1'b0;
                max_val_q <= '0;
                max_idx_q <= '0;
                idx_q     <= '0;
                thr_q     <= threshold;
            end else if (state_q == SCAN) begin
                acc_q <= acc_next;
                sat_q <= sat_next;
                // Strictly greater so ties keep the lowest index.
                if (sample > max_val_q) begin
                    max_val_q <= sample;
                    max_idx_q <= idx_q;
                end
                idx_q <= last ? '0 : idx_q + 1'b1;
            end
            if (accept) begin
                round_q <= round_q + 1'b1;
                cnt_q   <= PER_M1;
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (set_alarm)      alarm_q <= 1'b1;
            else if (clr_alarm) alarm_q <= 1'b0;
        end
    end

    assign rpt_valid   = (state_q == REPORT);
    assign rpt_total   = acc_q;
    assign rpt_sat     = sat_q;
    assign rpt_max_idx = max_idx_q;
    assign rpt_max_val = max_val_q;
    assign rpt_round   = round_q;
    assign alarm       = alarm_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_taint_sum_scanner.sv
// Directed bench for taint_sum_scanner with a report scoreboard.
module tb_taint_sum_scanner;
    localparam int N = 4, SW = 16, AW = 16, P = 8, RW = 16;

    logic            CLK = 1'b0;
    logic            ARST_N, enable, clr_alarm, rpt_ready;
    logic [N*SW-1:0] src_sum;
    logic [AW-1:0]   threshold;
    logic            rpt_valid, rpt_sat, alarm, busy;
    logic [AW-1:0]   rpt_total;
    logic [1:0]      rpt_max_idx;
    logic [SW-1:0]   rpt_max_val;
    logic [RW-1:0]   rpt_round;

    taint_sum_scanner #(.N_SRC(N), .SUM_W(SW), .ACC_W(AW), .PERIOD(P), .RND_W(RW)) dut (
        .CLK(CLK), .ARST_N(ARST_N), .enable(enable), .src_sum(src_sum),
        .threshold(threshold), .clr_alarm(clr_alarm), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_total(rpt_total), .rpt_sat(rpt_sat),
        .rpt_max_idx(rpt_max_idx), .rpt_max_val(rpt_max_val), .rpt_round(rpt_round),
        .alarm(alarm), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {int total; int sat; int idx; int val; int rnd;} rpt_t;
    rpt_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input int s0, input int s1, input int s2, input int s3);
        src_sum = {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    endtask

    // Reference model of one sweep, pushed when the stimulus is applied.
    task automatic push(input int s0, input int s1, input int s2, input int s3, input int rnd);
        int   s[4];
        rpt_t e;
        s = '{s0, s1, s2, s3};
        e = '{total: 0, sat: 0, idx: 0, val: 0, rnd: rnd};
        for (int i = 0; i < 4; i++) begin
            e.total += s[i];
            if (e.total > 65535) begin
                e.total = 65535;
                e.sat   = 1;
            end
            if (s[i] > e.val) begin
                e.val = s[i];
                e.idx = i;
            end
        end
        sb.push_back(e);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (rpt_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $error("FAIL wait_valid observed=timeout expected=rpt_valid");
        end
    endtask

    task automatic check_rpt(input string tag);
        rpt_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=report expected=empty_scoreboard", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".total"}, 32'(rpt_total), 32'(e.total));
            check({tag, ".sat"},   32'(rpt_sat),   32'(e.sat));
            check({tag, ".idx"},   32'(rpt_max_idx), 32'(e.idx));
            check({tag, ".val"},   32'(rpt_max_val), 32'(e.val));
            check({tag, ".round"}, 32'(rpt_round), 32'(e.rnd));
        end
    endtask

    initial begin
        int n;
        ARST_N = 1'b0; enable = 1'b0; clr_alarm = 1'b0; rpt_ready = 1'b0;
        src_sum = '0; threshold = '0;
        step(); step();
        check("rst.valid", 32'(rpt_valid), 0);
        check("rst.busy",  32'(busy), 0);
        check("rst.alarm", 32'(alarm), 0);
        check("rst.total", 32'(rpt_total), 0);
        check("rst.round", 32'(rpt_round), 0);
        ARST_N = 1'b1;
        step();

        // Basic sweep with tie on max and alarm over threshold.
        load(3, 9, 9, 1); threshold = 20; rpt_ready = 1'b1;
        push(3, 9, 9, 1, 0);
        enable = 1'b1;
        wait_valid(n);
        check("t1.latency", 32'(n), 5);
        check_rpt("t1");
        check("t1.alarm", 32'(alarm), 1);
        enable = 1'b0;
        step();
        check("t1.valid_drop", 32'(rpt_valid), 0);
        check("t1.idle", 32'(busy), 0);
        check("t1.round", 32'(rpt_round), 1);
        check("t1.sticky", 32'(alarm), 1);
        clr_alarm = 1'b1;
        step();
        clr_alarm = 1'b0;
        check("t1.clr", 32'(alarm), 0);

        // Saturation, then an all-zero sweep held under backpressure.
        load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF); threshold = 16'hFFFF;
        push(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1);
        enable = 1'b1;
        wait_valid(n);
        check_rpt("t2.sat");
        check("t2.no_alarm", 32'(alarm), 0);
        load(0, 0, 0, 0);
        push(0, 0, 0, 0, 2);
        step();
        rpt_ready = 1'b0;
        wait_valid(n);
        check_rpt("t2.zero");
        for (int i = 0; i < 10; i++) begin
            src_sum = {$urandom, $urandom};
            step();
            check("t3.hold_valid", 32'(rpt_valid), 1);
            check("t3.hold_total", 32'(rpt_total), 0);
            check("t3.hold_round", 32'(rpt_round), 2);
        end

        // Release backpressure; next report PERIOD+N+1 cycles on; alarm set/clear collision.
        load(5, 2, 7, 7); threshold = 20;
        push(5, 2, 7, 7, 3);
        rpt_ready = 1'b1;
        step();
        check("t3.accept_valid", 32'(rpt_valid), 0);
        check("t3.accept_round", 32'(rpt_round), 3);
        for (int i = 2; i <= P + N + 1; i++) begin
            if (i == P + N + 1) clr_alarm = 1'b1;
            step();
            if (i == P + N) check("t3.not_early", 32'(rpt_valid), 0);
        end
        check("t3.period", 32'(rpt_valid), 1);
        check("t5.set_wins", 32'(alarm), 1);
        check_rpt("t3");
        enable = 1'b0;
        step();
        clr_alarm = 1'b0;
        check("t5.clr_next", 32'(alarm), 0);
        check("t5.idle", 32'(busy), 0);
        check("t5.round", 32'(rpt_round), 4);

        // Enable dropped on the second scan cycle: sweep still reports, then stops.
        load(0, 4, 0, 4); threshold = 100;
        push(0, 4, 0, 4, 4);
        enable = 1'b1;
        step(); step();
        enable = 1'b0;
        wait_valid(n);
        check_rpt("t4");
        step();
        check("t4.busy", 32'(busy), 0);
        for (int i = 0; i < 20; i++) step();
        check("t4.stay_idle", 32'(busy), 0);
        check("t4.no_valid", 32'(rpt_valid), 0);
        check("t4.round", 32'(rpt_round), 5);

        // Reset mid-scan aborts; re-enable starts at round 0; X bits count as 0.
        load(1, 1, 1, 1);
        enable = 1'b1;
        step(); step();
        ARST_N = 1'b0;
        #1;
        check("t6.valid", 32'(rpt_valid), 0);
        check("t6.busy",  32'(busy), 0);
        check("t6.round", 32'(rpt_round), 0);
        check("t6.total", 32'(rpt_total), 0);
        check("t6.maxv",  32'(rpt_max_val), 0);
        step();
        ARST_N = 1'b1;
        load(1, 0, 1, 1);
        src_sum[SW +: SW] = 'x;
        push(1, 0, 1, 1, 0);
        wait_valid(n);
        check_rpt("t6");
        check("t6.alarm", 32'(alarm), 0);
        enable = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
